// File: rtl/gpu_pkg.sv
// gpu_pkg: shared definitions for the GPU command decoder slice.
//   - default geometry/colour/FIFO widths
//   - command opcode constants
//   - draw kind enum (matches the draw_kind_o encoding)
//   - decoder state enum
package gpu_pkg;

  localparam int DEF_WIDTH_BITS   = 10;
  localparam int DEF_HEIGHT_BITS  = 9;
  localparam int DEF_CHANNEL_BITS = 8;
  localparam int DEF_PARAM_BITS   = 25;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_SCREEN_H     = 480;

  localparam logic [3:0] OP_CLEAR        = 4'd0;
  localparam logic [3:0] OP_SET_P1       = 4'd1;
  localparam logic [3:0] OP_SET_P2       = 4'd2;
  localparam logic [3:0] OP_SET_RAD      = 4'd3;
  localparam logic [3:0] OP_DRAW_LINE    = 4'd4;
  localparam logic [3:0] OP_DRAW_RECT    = 4'd5;
  localparam logic [3:0] OP_DRAW_CIRCLE  = 4'd6;
  localparam logic [3:0] OP_DRAW_ARC     = 4'd7;
  localparam logic [3:0] OP_SET_ARC_MASK = 4'd8;

  typedef enum logic [1:0] {
    KIND_LINE   = 2'd0,
    KIND_RECT   = 2'd1,
    KIND_CIRCLE = 2'd2,
    KIND_ARC    = 2'd3
  } draw_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } dec_state_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: small synchronous command FIFO with registered count/pointers.
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   push, push_data   write request (ignored while full)
//   pop, pop_data     read request (ignored while empty); pop_data shows the head
//   full, empty       derived from the registered count
//   count             number of stored entries
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module gpu_cmd_fifo #(
  parameter int DATA_BITS  = 29,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        push,
  input  logic [DATA_BITS-1:0]        push_data,
  input  logic                        pop,
  output logic [DATA_BITS-1:0]        pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS-1:0]  rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/gpu_cmd_decoder.sv
// gpu_cmd_decoder: host command decoder in front of the raster engines.
// Commands {opcode, parameters} are queued in gpu_cmd_fifo and popped one per
// cycle while idle. Register commands update the shape/colour file; draw
// commands latch the colour and raise a draw request held until acknowledged,
// after which no further command is popped until the engine reports finished.
// Ports:
//   clk, n_rst                     clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o        host push handshake
//   opcode_i, parameters_i         command word
//   x1_o,y1_o,x2_o,y2_o,rad_o      shape registers
//   r_o,g_o,b_o, arc_mask_o        colour and arc octant mask
//   draw_valid_o/draw_kind_o/draw_ack_i, finished_i   raster handshake
//   busy_o, err_o                  activity flag, illegal/clamp pulse
// Build option: define GPU_CLIP_EN to saturate coordinates/radius to the
// screen (SCREEN_W/SCREEN_H) and pulse err_o whenever a clamp occurs.
module gpu_cmd_decoder
  import gpu_pkg::*;
#(
  parameter int WIDTH_BITS   = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS  = DEF_HEIGHT_BITS,
  parameter int CHANNEL_BITS = DEF_CHANNEL_BITS,
  parameter int PARAM_BITS   = DEF_PARAM_BITS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [3:0]              opcode_i,
  input  logic [PARAM_BITS-1:0]   parameters_i,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [WIDTH_BITS-1:0]   rad_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic [7:0]              arc_mask_o,
  output logic                    draw_valid_o,
  output logic [1:0]              draw_kind_o,
  input  logic                    draw_ack_i,
  input  logic                    finished_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int DATA_BITS = 4 + PARAM_BITS;

  logic [DATA_BITS-1:0]        fifo_dout;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic [3:0]              op;
  logic [PARAM_BITS-1:0]   params;
  logic                    params_unused;
  logic [WIDTH_BITS-1:0]   x_field;
  logic [HEIGHT_BITS-1:0]  y_field;
  logic [WIDTH_BITS-1:0]   x_sat;
  logic [HEIGHT_BITS-1:0]  y_sat;
  logic                    x_over;
  logic                    y_over;
  logic                    x_clip;
  logic                    y_clip;

  dec_state_t              state_q, state_d;
  draw_kind_t              kind_q, kind_d;
  logic [WIDTH_BITS-1:0]   x1_d, x2_d, rad_d;
  logic [HEIGHT_BITS-1:0]  y1_d, y2_d;
  logic [CHANNEL_BITS-1:0] r_d, g_d, b_d;
  logic [7:0]              mask_d;
  logic                    err_d;

  assign cmd_ready_o = !fifo_full;

  gpu_cmd_fifo #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (cmd_valid_i),
    .push_data({opcode_i, parameters_i}),
    .pop      (fifo_pop),
    .pop_data (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign op       = fifo_dout[DATA_BITS-1 -: 4];
  assign params   = fifo_dout[PARAM_BITS-1:0];
  assign x_field  = params[WIDTH_BITS-1:0];
  assign y_field  = params[WIDTH_BITS+HEIGHT_BITS-1:WIDTH_BITS];
  assign x_over   = (32'(x_field) > SCREEN_W - 1);
  assign y_over   = (32'(y_field) > SCREEN_H - 1);
  // Payload bits beyond the widest field are legitimately ignored.
  assign params_unused = ^params;

`ifdef GPU_CLIP_EN
  assign x_sat  = x_over ? WIDTH_BITS'(SCREEN_W - 1) : x_field;
  assign y_sat  = y_over ? HEIGHT_BITS'(SCREEN_H - 1) : y_field;
  assign x_clip = x_over;
  assign y_clip = y_over;
`else
  logic clip_unused;
  assign clip_unused = x_over ^ y_over;
  assign x_sat  = x_field;
  assign y_sat  = y_field;
  assign x_clip = 1'b0;
  assign y_clip = 1'b0;
`endif

  assign busy_o       = (state_q != ST_IDLE) || (fifo_count != '0);
  assign draw_valid_o = (state_q == ST_ISSUE);
  assign draw_kind_o  = kind_q;

  // Next-state and register-file decode; commands are only popped while idle.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    x1_d     = x1_o;
    y1_d     = y1_o;
    x2_d     = x2_o;
    y2_d     = y2_o;
    rad_d    = rad_o;
    r_d      = r_o;
    g_d      = g_o;
    b_d      = b_o;
    mask_d   = arc_mask_o;
    err_d    = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          case (op)
            OP_CLEAR: begin
              x1_d   = '0;
              y1_d   = '0;
              x2_d   = '0;
              y2_d   = '0;
              rad_d  = '0;
              r_d    = '0;
              g_d    = '0;
              b_d    = '0;
              mask_d = 8'hFF;
            end
            OP_SET_P1: begin
              x1_d  = x_sat;
              y1_d  = y_sat;
              err_d = x_clip || y_clip;
            end
            OP_SET_P2: begin
              x2_d  = x_sat;
              y2_d  = y_sat;
              err_d = x_clip || y_clip;
            end
            OP_SET_RAD: begin
              rad_d = x_sat;
              err_d = x_clip;
            end
            OP_DRAW_LINE, OP_DRAW_RECT, OP_DRAW_CIRCLE, OP_DRAW_ARC: begin
              b_d     = params[CHANNEL_BITS-1:0];
              g_d     = params[2*CHANNEL_BITS-1:CHANNEL_BITS];
              r_d     = params[3*CHANNEL_BITS-1:2*CHANNEL_BITS];
              // Draw opcodes 4..7 map onto kinds 0..3 through their low bits.
              kind_d  = draw_kind_t'(op[1:0]);
              state_d = ST_ISSUE;
            end
            OP_SET_ARC_MASK: mask_d = params[7:0];
            default:         err_d  = 1'b1;
          endcase
        end
      end
      ST_ISSUE: begin
        // An engine that completes in the accept cycle skips BUSY entirely.
        if (draw_ack_i) begin
          state_d = finished_i ? ST_IDLE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (finished_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register file; reset aborts any draw in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      kind_q     <= KIND_LINE;
      x1_o       <= '0;
      y1_o       <= '0;
      x2_o       <= '0;
      y2_o       <= '0;
      rad_o      <= '0;
      r_o        <= '0;
      g_o        <= '0;
      b_o        <= '0;
      arc_mask_o <= 8'hFF;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      x1_o       <= x1_d;
      y1_o       <= y1_d;
      x2_o       <= x2_d;
      y2_o       <= y2_d;
      rad_o      <= rad_d;
      r_o        <= r_d;
      g_o        <= g_d;
      b_o        <= b_d;
      arc_mask_o <= mask_d;
      err_o      <= err_d;
    end
  end

endmodule
